// File: rtl/maze_nav_core.sv
// maze_nav_core: grid-maze player movement engine.
// Tracks the player (x,y), checks moves against grid edges and a run-time
// wall map, runs the IDLE/PLAY/PAUSED/WON/LOST game flow, counts steps in
// saturating BCD and stretches blocked moves into a timed bump (beep) pulse.
module maze_nav_core #(
    parameter int COLS        = 8,
    parameter int ROWS        = 8,
    parameter int STEP_DIGITS = 2,
    parameter int BEEP_CYCLES = 5000000,
    localparam int XW = $clog2(COLS),
    localparam int YW = $clog2(ROWS),
    localparam int N  = ROWS * COLS,
    localparam int SW = 4 * STEP_DIGITS
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          start,
    input  logic          pause,
    input  logic          timeout,
    input  logic [3:0]    move_req,
    input  logic [N-1:0]  wall_map,
    input  logic [XW-1:0] start_x,
    input  logic [YW-1:0] start_y,
    input  logic [XW-1:0] goal_x,
    input  logic [YW-1:0] goal_y,
    output logic [XW-1:0] pos_x,
    output logic [YW-1:0] pos_y,
    output logic [N-1:0]  pos_map,
    output logic [2:0]    state,
    output logic [SW-1:0] steps,
    output logic          step_ovf,
    output logic          bump
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(BEEP_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PLAY   = 3'd1,
        PAUSED = 3'd2,
        WON    = 3'd3,
        LOST   = 3'd4
    } state_t;

    state_t        state_q;
    logic [XW-1:0] pos_x_q;
    logic [YW-1:0] pos_y_q;
    logic [SW-1:0] steps_q;
    logic          ovf_q;
    logic [CW-1:0] beep_q;

    // move decode
    logic [XW-1:0] tgt_x;
    logic [YW-1:0] tgt_y;
    logic [IW-1:0] tgt_idx;
    logic [IW-1:0] cur_idx;
    logic          mv_valid;
    logic          mv_edge;
    logic          mv_blocked;
    logic          mv_legal;

    // step counter
    logic [SW-1:0] steps_d;
    logic          all9;

    // Single-bit move requests form a target cell; the edge check comes first
    // so a wrapped target coordinate never reaches the wall lookup result.
    always_comb begin
        tgt_x    = pos_x_q;
        tgt_y    = pos_y_q;
        mv_valid = 1'b1;
        mv_edge  = 1'b0;
        case (move_req)
            4'b1000: begin mv_edge = (pos_x_q == '0);              tgt_x = pos_x_q - 1'b1; end
            4'b0100: begin mv_edge = (pos_x_q == XW'(COLS - 1));   tgt_x = pos_x_q + 1'b1; end
            4'b0010: begin mv_edge = (pos_y_q == YW'(ROWS - 1));   tgt_y = pos_y_q + 1'b1; end
            4'b0001: begin mv_edge = (pos_y_q == '0);              tgt_y = pos_y_q - 1'b1; end
            default: mv_valid = 1'b0;
        endcase
        tgt_idx    = IW'(tgt_y) * IW'(COLS) + IW'(tgt_x);
        mv_blocked = mv_valid && (mv_edge || wall_map[tgt_idx]);
        mv_legal   = mv_valid && !mv_edge && !wall_map[tgt_idx];
    end

    // BCD ripple increment; all9 means every digit was 9 (saturate instead)
    always_comb begin
        logic carry;
        carry   = 1'b1;
        steps_d = steps_q;
        for (int i = 0; i < STEP_DIGITS; i++) begin
            if (carry) begin
                if (steps_q[4*i +: 4] == 4'd9) begin
                    steps_d[4*i +: 4] = 4'd0;
                end else begin
                    steps_d[4*i +: 4] = steps_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        all9 = carry;
    end

    // Game FSM: position, steps, overflow flag and beep counter
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pos_x_q <= '0;
            pos_y_q <= '0;
            steps_q <= '0;
            ovf_q   <= 1'b0;
            beep_q  <= '0;
        end else begin
            // beep keeps counting down in every state
            if (beep_q != '0) beep_q <= beep_q - 1'b1;

            if (start) begin
                pos_x_q <= start_x;
                pos_y_q <= start_y;
                steps_q <= '0;
                ovf_q   <= 1'b0;
                beep_q  <= '0;
                state_q <= (start_x == goal_x && start_y == goal_y) ? WON : PLAY;
            end else begin
                case (state_q)
                    PLAY: begin
                        if (timeout) begin
                            state_q <= LOST;
                        end else if (pause) begin
                            state_q <= PAUSED;
                        end else if (mv_blocked) begin
                            beep_q <= CW'(BEEP_CYCLES);
                        end else if (mv_legal) begin
                            pos_x_q <= tgt_x;
                            pos_y_q <= tgt_y;
                            if (all9) ovf_q   <= 1'b1;
                            else      steps_q <= steps_d;
                            if (tgt_x == goal_x && tgt_y == goal_y) state_q <= WON;
                        end
                    end
                    PAUSED: begin
                        if (timeout)     state_q <= LOST;
                        else if (!pause) state_q <= PLAY;
                    end
                    default: ;  // IDLE, WON, LOST wait for start
                endcase
            end
        end
    end

    assign cur_idx  = IW'(pos_y_q) * IW'(COLS) + IW'(pos_x_q);
    assign pos_map  = (state_q == IDLE) ? '0 : (N'(1) << cur_idx);
    assign pos_x    = pos_x_q;
    assign pos_y    = pos_y_q;
    assign state    = state_q;
    assign steps    = steps_q;
    assign step_ovf = ovf_q;
    assign bump     = (beep_q != '0);

endmodule

// File: tb/tb_maze_nav_core.sv
// tb_maze_nav_core: directed checks of maze_nav_core on an 8x8 grid.
// dut_a uses two BCD digits, dut_b one digit for the saturation case;
// both share every input.
module tb_maze_nav_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, pause = 1'b0, timeout = 1'b0;
    logic [3:0]  move_req = '0;
    logic [63:0] wall_map = '0;
    logic [2:0]  start_x = '0, start_y = '0, goal_x = '0, goal_y = '0;

    logic [2:0]  pos_x, pos_y, state;
    logic [63:0] pos_map;
    logic [7:0]  steps;
    logic        step_ovf, bump;

    logic [2:0]  pos_x_b, pos_y_b, state_b;
    logic [63:0] pos_map_b;
    logic [3:0]  steps_b;
    logic        step_ovf_b, bump_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    maze_nav_core #(.COLS(8), .ROWS(8), .STEP_DIGITS(2), .BEEP_CYCLES(10)) dut_a (
        .clk_in(clk), .rst(rst), .start(start), .pause(pause), .timeout(timeout),
        .move_req(move_req), .wall_map(wall_map), .start_x(start_x), .start_y(start_y),
        .goal_x(goal_x), .goal_y(goal_y), .pos_x(pos_x), .pos_y(pos_y),
        .pos_map(pos_map), .state(state), .steps(steps), .step_ovf(step_ovf), .bump(bump)
    );

    maze_nav_core #(.COLS(8), .ROWS(8), .STEP_DIGITS(1), .BEEP_CYCLES(10)) dut_b (
        .clk_in(clk), .rst(rst), .start(start), .pause(pause), .timeout(timeout),
        .move_req(move_req), .wall_map(wall_map), .start_x(start_x), .start_y(start_y),
        .goal_x(goal_x), .goal_y(goal_y), .pos_x(pos_x_b), .pos_y(pos_y_b),
        .pos_map(pos_map_b), .state(state_b), .steps(steps_b), .step_ovf(step_ovf_b),
        .bump(bump_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // all tasks are entered and left on a falling edge
    task automatic do_start(input logic [2:0] sx, sy, gx, gy);
        start_x = sx; start_y = sy; goal_x = gx; goal_y = gy;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_move(input logic [3:0] m);
        move_req = m;
        @(negedge clk);
        move_req = 4'b0000;
    endtask

    // count cycles bump stays high, starting with the current sample
    task automatic bump_len(output int n);
        n = 0;
        while (bump && n < 30) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_pos_x", pos_x, 0);
        chk("rst_pos_y", pos_y, 0);
        chk("rst_map", pos_map, 0);
        chk("rst_steps", steps, 0);
        chk("rst_bump", bump, 0);
        chk("rst_ovf", step_ovf, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_move_ignored", state, 0);

        // start at (0,1), goal (7,1)
        do_start(3'd0, 3'd1, 3'd7, 3'd1);
        chk("start_state", state, 1);
        chk("start_pos_y", pos_y, 1);
        chk("start_map", pos_map, 64'h100);

        // left edge block
        pulse_move(4'b1000);
        chk("edge_l_pos_x", pos_x, 0);
        chk("edge_l_steps", steps, 0);
        chk("edge_l_bump", bump, 1);
        bump_len(n);
        chk("edge_l_bump_len", n, 10);

        // walk to goal
        for (int i = 1; i <= 7; i++) begin
            pulse_move(4'b0100);
            chk($sformatf("walk_x%0d", i), pos_x, i);
        end
        chk("goal_state", state, 3);
        chk("goal_steps", steps, 8'h07);
        chk("goal_map", pos_map, 64'h8000);
        pulse_move(4'b1000);
        chk("won_hold", pos_x, 7);

        // right edge block at (7,1)
        do_start(3'd7, 3'd1, 3'd0, 3'd7);
        pulse_move(4'b0100);
        chk("edge_r_pos_x", pos_x, 7);
        chk("edge_r_steps", steps, 0);
        chk("edge_r_bump", bump, 1);

        // wall at (3,1) = bit 11; start clears the running bump
        wall_map = 64'h800;
        do_start(3'd2, 3'd1, 3'd7, 3'd7);
        chk("start_clr_bump", bump, 0);
        pulse_move(4'b0100);
        chk("wall_pos_x", pos_x, 2);
        chk("wall_bump", bump, 1);
        repeat (7) @(negedge clk);
        chk("wall_bump_cnt3", bump, 1);
        pulse_move(4'b0100);
        bump_len(n);
        chk("retrig_len", n, 10);

        // pause / timeout
        wall_map = '0;
        do_start(3'd0, 3'd1, 3'd7, 3'd1);
        pulse_move(4'b0100);
        chk("pre_pause_x", pos_x, 1);
        pause = 1'b1;
        pulse_move(4'b0100);
        chk("pause_state", state, 2);
        chk("pause_drop_x", pos_x, 1);
        pulse_move(4'b0100);
        chk("paused_move_x", pos_x, 1);
        pause = 1'b0;
        @(negedge clk);
        chk("unpause_state", state, 1);
        pause = 1'b1;
        @(negedge clk);
        timeout = 1'b1;
        @(negedge clk);
        chk("timeout_state", state, 4);
        timeout = 1'b0;
        pause = 1'b0;
        pulse_move(4'b0100);
        chk("lost_move_x", pos_x, 1);
        chk("lost_hold", state, 4);
        do_start(3'd0, 3'd1, 3'd7, 3'd1);
        chk("restart_state", state, 1);
        chk("restart_x", pos_x, 0);
        chk("restart_steps", steps, 0);

        // illegal / simultaneous
        pulse_move(4'b0110);
        chk("multi_x", pos_x, 0);
        chk("multi_bump", bump, 0);
        chk("multi_steps", steps, 0);
        pulse_move(4'b0100);
        move_req = 4'b0100;
        do_start(3'd0, 3'd1, 3'd7, 3'd1);
        move_req = 4'b0000;
        chk("start_wins_x", pos_x, 0);
        chk("start_wins_steps", steps, 0);

        // saturation (dut_b) and BCD carry (dut_a)
        do_start(3'd0, 3'd1, 3'd7, 3'd7);
        for (int i = 1; i <= 9; i++) pulse_move(i[0] ? 4'b0100 : 4'b1000);
        chk("sat9_steps_b", steps_b, 9);
        chk("sat9_ovf_b", step_ovf_b, 0);
        chk("sat9_x_b", pos_x_b, 1);
        pulse_move(4'b1000);
        chk("sat10_x_b", pos_x_b, 0);
        chk("sat10_steps_b", steps_b, 9);
        chk("sat10_ovf_b", step_ovf_b, 1);
        chk("bcd10_steps_a", steps, 8'h10);
        chk("bcd10_ovf_a", step_ovf, 0);

        // async reset mid-bump
        pulse_move(4'b1000);
        chk("pre_rst_bump", bump, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_state", state, 0);
        chk("arst_x", pos_x, 0);
        chk("arst_y", pos_y, 0);
        chk("arst_map", pos_map, 0);
        chk("arst_bump", bump, 0);
        chk("arst_ovf_b", step_ovf_b, 0);
        chk("arst_steps_b", steps_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/maze_nav_core.md
Name: maze_nav_core

Overview:
- Parametrised player-movement engine for the grid maze game. Successor to the fixed 8x8 direction logic.
- Holds player position as (x,y) coordinates and derives the one-hot display map for the LED matrix driver.
- Wall map, start and goal positions are run-time inputs, so any number of maps can sit in an external ROM.
- Adds grid-edge blocking (no row wrap), a play/pause/won/lost state machine, a saturating BCD step counter and a timed bump (beep) output.

Parameters:
- COLS, 8, grid width; 2..16.
- ROWS, 8, grid height; 2..16.
- STEP_DIGITS, 2, BCD digits in the step counter.
- BEEP_CYCLES, 5000000, clk_in cycles that bump stays high after a blocked move (100 ms at 50 MHz).
- Derived localparams: XW = $clog2(COLS), YW = $clog2(ROWS), N = ROWS*COLS.

Ports:
- clk_in  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; loads start position, clears steps, enters PLAY.
- pause  in  1  level; freezes movement while high.
- timeout  in  1  level from the countdown timer; forces LOST.
- move_req  in  4  one-cycle debounced pulses: [3] x-1, [2] x+1, [1] y+1, [0] y-1.
- wall_map  in  N  1 = wall; bit index = y*COLS + x.
- start_x  in  XW  start column.
- start_y  in  YW  start row.
- goal_x  in  XW  goal column.
- goal_y  in  YW  goal row.
- pos_x  out  XW  current column.
- pos_y  out  YW  current row.
- pos_map  out  N  one-hot of (pos_x,pos_y); all zero in IDLE.
- state  out  3  IDLE=0, PLAY=1, PAUSED=2, WON=3, LOST=4.
- steps  out  4*STEP_DIGITS  BCD step count; digit 0 in the LSBs.
- step_ovf  out  1  sticky; set when a move is attempted with steps all 9s.
- bump  out  1  beep enable.

Behaviour:
- Reset (async): state=IDLE, pos_x=0, pos_y=0, pos_map=0, steps=0, step_ovf=0, bump=0, beep counter=0.
- All other updates are on the clk_in rising edge. Outputs are registered except pos_map, which is decoded combinationally from the pos registers and gated to zero in IDLE.
- Priority in every state: start > timeout > pause > move.
- start, any state:
  - Next cycle: pos=(start_x,start_y), steps=0, step_ovf=0, bump=0.
  - Next state: WON if start position equals goal, else PLAY.
  - The start cell is not checked against wall_map.
- IDLE: waits for start. timeout, pause and move_req are ignored.
- PLAY:
  - timeout=1 -> LOST.
  - Else pause=1 -> PAUSED; any move_req in that cycle is dropped.
  - Else a move is evaluated.
- PAUSED: pause=0 -> PLAY; timeout=1 -> LOST; move_req ignored.
- WON, LOST: position and steps are held; only start leaves these states.
- Move evaluation (PLAY only):
  - move_req with exactly one bit set forms a target cell.
  - Zero or multiple bits set: no action, no bump.
  - Blocked if the target is off-grid (x-1 at x=0, x+1 at x=COLS-1, y-1 at y=0, y+1 at y=ROWS-1) or wall_map[target]=1.
  - Blocked: position and steps unchanged. Beep counter loads BEEP_CYCLES and bump=1 from the next cycle.
  - Legal: position updates next cycle (latency 1) and steps increments.
  - If the target equals the goal, state becomes WON in the same update.
- Steps arithmetic:
  - BCD ripple increment: a digit at 9 rolls to 0 and carries.
  - When all digits are 9, the count saturates (no wrap) and step_ovf is set; the move itself still occurs.
- Bump:
  - bump = (beep counter != 0). The counter decrements each cycle while nonzero.
  - A new blocked move reloads the counter (retrigger). The counter keeps running through PAUSED, WON and LOST; only start or rst clears it.
- wall_map, goal and start inputs are sampled each cycle. A map switch mid-game takes effect on the next move evaluation and is not auto-restarted.
- There is no row wrap: leftmost and rightmost columns are hard edges (the 64-bit shift behaviour is not reproduced).

Test Plan:
- Reset-to-goal:
  - Setup: defaults, wall_map=0, start (0,1), goal (7,1).
  - Stimulus: rst, start, then 7 pulses of move_req=0100.
  - Required: pos_x steps 1..7; state=WON one cycle after the 7th pulse; steps=8'h07; pos_map=1<<15.
- Edge block:
  - Stimulus: at (0,1) pulse 1000.
  - Required: position unchanged, steps unchanged, bump high for exactly BEEP_CYCLES (set BEEP_CYCLES=10 in bench).
  - Also at (7,1) pulse 0100 -> same blocked response.
- Wall block:
  - Setup: wall_map bit 11 set (x=3,y=1).
  - Stimulus: from (2,1) pulse 0100.
  - Required: blocked, bump=1.
  - A retrigger at counter=3 reloads bump to the full 10 cycles.
- Pause/timeout:
  - Pause=1 with a move_req in the same cycle: PAUSED, no move.
  - timeout=1 while PAUSED: LOST.
  - Moves in LOST are ignored.
  - start: PLAY at the start position with steps=0.
- Illegal/simultaneous:
  - move_req=0110: no move, no bump.
  - start and move_req in the same cycle: start wins.
- Saturation:
  - Setup: STEP_DIGITS=1.
  - Stimulus: 10 legal moves.
  - Required: steps=9 after the 9th move; 10th move moves the player, steps stays 9, step_ovf=1.
  - Async rst mid-bump: all outputs return to reset values immediately.
